// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - three-digit multiplexed 7-segment driver for packed BCD
// Double-buffers the BCD value and swaps it in only at frame boundaries.
module bcd_seg_scan #(
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_tick,
    output logic        err
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0] AN_OFF  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    dig_idx_q, dig_idx_d;
    logic [11:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic [11:0]   disp_q, disp_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          frame_tick_q, frame_tick_d;
    logic          err_q, err_d;

    logic          terminal;
    logic          boundary;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_act;
    logic [2:0]    an_act;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        terminal  = (div_cnt_q == DIV_LAST);
        boundary  = terminal && (dig_idx_q == 2'd2);

        div_cnt_d = terminal ? '0 : div_cnt_q + CW'(1);
        dig_idx_d = dig_idx_q;
        if (terminal) begin
            dig_idx_d = (dig_idx_q == 2'd2) ? 2'd0 : dig_idx_q + 2'd1;
        end

        shadow_d  = load ? bcd_in : shadow_q;
        pending_d = load ? 1'b1 : pending_q;
        disp_d    = disp_q;
        if (boundary) begin
            // A load coinciding with the boundary bypasses the shadow.
            pending_d = 1'b0;
            if (load) begin
                disp_d = bcd_in;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
        end

        case (dig_idx_q)
            2'd1:    nib = disp_q[7:4];
            2'd2:    nib = disp_q[11:8];
            default: nib = disp_q[3:0];
        endcase

        // Invalid nibbles are never zero, so they never trigger blanking.
        blank = blank_lz &&
                (((dig_idx_q == 2'd2) && (disp_q[11:8] == 4'd0)) ||
                 ((dig_idx_q == 2'd1) && (disp_q[11:4] == 8'd0)));

        seg_act = decode(nib);
        an_act  = 3'b001 << dig_idx_q;

        seg_d = blank ? SEG_OFF : (SEG_ACTIVE_LOW ? ~seg_act : seg_act);
        an_d  = blank ? AN_OFF  : (AN_ACTIVE_LOW  ? ~an_act  : an_act);

        err_d = (disp_q[11:8] > 4'd9) || (disp_q[7:4] > 4'd9) || (disp_q[3:0] > 4'd9);
        frame_tick_d = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            dig_idx_q    <= 2'd0;
            shadow_q     <= 12'h000;
            pending_q    <= 1'b0;
            disp_q       <= 12'h000;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            dig_idx_q    <= dig_idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            disp_q       <= disp_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
            err_q        <= err_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb/tb_bcd_seg_scan.sv - self-checking bench for bcd_seg_scan
// A cycle-count model predicts pins every cycle; directed literals pin the model.
module tb_bcd_seg_scan;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bcd_in = 12'h000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame_tick;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd_seg_scan #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
        .seg(seg), .an(an), .frame_tick(frame_tick), .err(err)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int         m_n = 0;
    logic [11:0] m_disp = 12'h000;
    logic [11:0] m_shadow = 12'h000;
    bit          m_pend = 1'b0;
    logic [6:0]  e_seg = 7'h7F;
    logic [2:0]  e_an = 3'b111;
    logic        e_tick = 1'b0;
    logic        e_err = 1'b0;
    bit          started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the lit digit is (edges since reset / DIV) mod 3.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_n = 0; m_disp = 12'h000; m_shadow = 12'h000; m_pend = 1'b0;
            e_seg = 7'h7F; e_an = 3'b111; e_tick = 1'b0; e_err = 1'b0;
            started = 1'b1;
        end else begin
            int d, pos, nibv;
            bit blank, bnd;
            d    = (m_n / DIV) % 3;
            pos  = m_n % DIV;
            nibv = (m_disp >> (4 * d)) % 16;
            blank = blank_lz && ((d == 2 && m_disp / 256 == 0) || (d == 1 && m_disp / 16 == 0));
            e_seg = blank ? 7'h7F : ~((nibv < 10) ? seg_tab[nibv] : 7'h40);
            e_an  = blank ? 3'b111 : ~(3'b001 << d);
            e_err = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if ((m_disp >> (4 * k)) % 16 > 9) e_err = 1'b1;
            end
            bnd = (pos == DIV - 1) && (d == 2);
            e_tick = bnd;
            if (load) m_shadow = bcd_in;
            if (bnd) begin
                if (load) m_disp = bcd_in;
                else if (m_pend) m_disp = m_shadow;
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            m_n++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("model_seg", {25'd0, seg}, {25'd0, e_seg});
            check("model_an", {29'd0, an}, {29'd0, e_an});
            check("model_tick", {31'd0, frame_tick}, {31'd0, e_tick});
            check("model_err", {31'd0, err}, {31'd0, e_err});
        end
    end

    task automatic do_load(input logic [11:0] v);
        @(negedge clk); #1;
        bcd_in = v; load = 1'b1;
        @(negedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (frame_tick) ok = 1'b1;
        end
        check("tick_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic pin(input string name, input logic [7:0] s8, input logic [2:0] a);
        check({name, "_seg"}, {24'd0, 1'b1, seg}, {24'd0, s8});
        check({name, "_an"}, {29'd0, an}, {29'd0, a});
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            load = ~load; bcd_in = 12'h999;
            @(negedge clk);
            pin("rst_hold", 8'hFF, 3'b111);
            check("rst_err", {31'd0, err}, 32'd0);
            check("rst_tick", {31'd0, frame_tick}, 32'd0);
        end
        #1; rst = 1'b0; load = 1'b0;
        @(negedge clk);
        pin("rst_rel", 8'hC0, 3'b110);

        do_load(12'h255);
        wait_tick();
        @(negedge clk);          pin("b255_ones", 8'h92, 3'b110);
        repeat (4) @(negedge clk); pin("b255_tens", 8'h92, 3'b101);
        repeat (4) @(negedge clk); pin("b255_hund", 8'hA4, 3'b011);

        wait_tick();
        repeat (5) @(negedge clk);
        do_load(12'h123);
        do_load(12'h456);
        wait_tick();
        @(negedge clk);          pin("tear_ones", 8'h82, 3'b110);
        repeat (4) @(negedge clk); pin("tear_tens", 8'h92, 3'b101);
        repeat (4) @(negedge clk); pin("tear_hund", 8'h99, 3'b011);

        blank_lz = 1'b1;
        do_load(12'h007);
        wait_tick();
        @(negedge clk);          pin("blk7_ones", 8'hF8, 3'b110);
        repeat (4) @(negedge clk); pin("blk7_tens", 8'hFF, 3'b111);
        repeat (4) @(negedge clk); pin("blk7_hund", 8'hFF, 3'b111);
        do_load(12'h100);
        wait_tick();
        @(negedge clk);          pin("b100_ones", 8'hC0, 3'b110);
        repeat (4) @(negedge clk); pin("b100_tens", 8'hC0, 3'b101);
        repeat (4) @(negedge clk); pin("b100_hund", 8'hF9, 3'b011);

        blank_lz = 1'b0;
        do_load(12'h1A9);
        wait_tick();
        @(negedge clk);          pin("inv_ones", 8'h90, 3'b110);
        check("inv_err_ones", {31'd0, err}, 32'd1);
        repeat (4) @(negedge clk); pin("inv_tens", 8'hBF, 3'b101);
        check("inv_err_tens", {31'd0, err}, 32'd1);
        do_load(12'h199);
        wait_tick();
        check("inv_err_old", {31'd0, err}, 32'd1);
        @(negedge clk);
        check("inv_err_clr", {31'd0, err}, 32'd0);

        wait_tick();
        repeat (11) @(negedge clk);
        #1; bcd_in = 12'h321; load = 1'b1;
        @(negedge clk);
        check("coin_tick", {31'd0, frame_tick}, 32'd1);
        #1; load = 1'b0;
        @(negedge clk);          pin("coin_ones", 8'hF9, 3'b110);

        repeat (4) @(negedge clk);
        #1; rst = 1'b1;
        #1; pin("mid_rst", 8'hFF, 3'b111);
        @(negedge clk); #1; rst = 1'b0;
        @(negedge clk);          pin("resume", 8'hC0, 3'b110);
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Three-digit multiplexed 7-segment display driver that consumes the 12-bit packed BCD word produced by the binary-to-BCD converter (hundreds/tens/ones nibbles). It double-buffers the value, swaps it in only at frame boundaries so a digit never shows a torn value, and time-multiplexes one shared segment bus across three common-anode digits. It optionally blanks leading zeros and flags non-BCD nibbles. It is the last stage before the board pins.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit is lit; legal range 2..2^20.
- SEG_ACTIVE_LOW, 1: 1 drives segments low-true, 0 high-true.
- AN_ACTIVE_LOW, 1: 1 drives anodes low-true, 0 high-true.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bcd_in  in  12  packed BCD {hundreds[11:8], tens[7:4], ones[3:0]}.
- load  in  1  single-cycle strobe; captures bcd_in.
- blank_lz  in  1  level; 1 enables leading-zero blanking.
- seg  out  7  {g,f,e,d,c,b,a}, registered, polarity per SEG_ACTIVE_LOW.
- an  out  3  an[0]=ones, an[1]=tens, an[2]=hundreds; registered, one-hot active.
- frame_tick  out  1  one-cycle pulse when a new frame starts (digit 0 begins).
- err  out  1  registered; 1 while the displayed value holds any nibble > 9.

## Operation
- Registers: div_cnt (0..REFRESH_DIV-1), dig_idx (0,1,2), shadow[11:0], pending, disp[11:0].
- div_cnt increments every cycle; at REFRESH_DIV-1 it wraps to 0 (the "terminal" cycle) and dig_idx advances 0→1→2→0.
- load=1: shadow ← bcd_in, pending ← 1. Back-to-back loads: latest wins.
- Frame boundary = terminal cycle with dig_idx==2. At the boundary: if load=1 the same cycle, disp ← bcd_in; else if pending, disp ← shadow; pending ← 0 in both cases. frame_tick=1 on the following cycle.
- Decode (active-high form, before polarity): 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F; nibble A–F → 40 (dash, g only).
- Blanking (blank_lz=1): hundreds blank if disp[11:8]==0; tens blank if disp[11:4]==0. Ones never blank. A blanked digit has its anode inactive and all segments inactive for its slot. Invalid nibbles never count as zero.
- Non-blanked slot: only an[dig_idx] active, seg = decoded disp nibble for dig_idx.
- err = |(nibble>9) over disp's three nibbles.

## Timing
- Reset (async assert): div_cnt=0, dig_idx=0, shadow=0, pending=0, disp=0, seg=all inactive (7'h7F when active-low), an=all inactive (3'b111 when active-low), frame_tick=0, err=0.
- First clock edge after reset release: an[0] active, seg = "0" (ones of disp=0).
- seg/an/err are registered: one-cycle latency from dig_idx/disp change to pins.
- Each digit is lit exactly REFRESH_DIV cycles; a frame is 3·REFRESH_DIV cycles.
- load→display latency: up to 3·REFRESH_DIV+1 cycles; a load in the terminal cycle of digit 2 appears on the next edge (ones slot).
- Reset asserted mid-scan: all state returns to reset values immediately; any pending value is discarded.
- blank_lz change takes effect at the next registered output update (one cycle), not at frame boundary.

## Test plan
- Reset: hold rst for 3 cycles with load pulsing → seg=7F, an=111, err=0, frame_tick=0; after release an=110, seg=C0 (active-low "0").
- Basic scan, REFRESH_DIV=4: load 12'h255 → after next frame_tick, ones slot an=110 seg=92 ("5"), 4 cycles later an=101 seg=92, then an=011 seg=A4 ("2"); each slot exactly 4 cycles.
- Tear-free update: load 12'h123 mid-slot of tens, then 12'h456 → display keeps old value until boundary, then shows 4-5-6; 123 never appears.
- Blanking: blank_lz=1, load 12'h007 → hundreds/tens slots an=111 seg=7F, ones shows "7" (F8); load 12'h100 with blank_lz=1 → all three digits lit ("1","0","0").
- Invalid nibble: load 12'h1A9 → tens slot seg=BF (dash), err=1 for whole frame; load 12'h199 → err returns 0 after boundary.
- Boundary coincidence and reset mid-scan: load 12'h321 in the digit-2 terminal cycle → next edge ones slot shows "1"; assert rst during tens slot → outputs inactive immediately, resume from ones showing "0".
